// File: rtl/queue_calc_sequencer_if.sv
// Token, queue and result signals of the calculator operand-queue sequencer.
// master: the sequencer. slave: the token source / queue / result consumer.
interface queue_calc_sequencer_if #(
    parameter int DATA_W = 8
);
    logic                  tok_valid;
    logic                  tok_ready;
    logic                  tok_is_op;
    logic [DATA_W-1:0]     tok_data;
    logic [1:0]            q_opcode;
    logic [DATA_W-1:0]     q_back;
    logic [2*DATA_W-1:0]   q_top_conc;
    logic                  q_is_empty;
    logic                  q_is_err;
    logic                  res_valid;
    logic [DATA_W-1:0]     res_data;
    logic                  busy;
    logic                  err;
    logic [1:0]            err_code;

    modport master (
        input  tok_valid, tok_is_op, tok_data, q_top_conc, q_is_empty, q_is_err,
        output tok_ready, q_opcode, q_back, res_valid, res_data, busy, err, err_code
    );

    modport slave (
        output tok_valid, tok_is_op, tok_data, q_top_conc, q_is_empty, q_is_err,
        input  tok_ready, q_opcode, q_back, res_valid, res_data, busy, err, err_code
    );
endinterface

// File: rtl/queue_calc_sequencer.sv
// Initiator side of the calculator operand queue: accepts operand/operator
// tokens, issues push/combine/pop opcodes to the queue and reports the result.
// Optional feature macro: QSEQ_DIV_EN enables operator 6 (unsigned a/b).
//
// state   | meaning
// IDLE    | waiting for a token
// EXEC    | operator accepted, ALU result being registered
// ISSUE   | one cycle driving the queued opcode (push/combine/pop)
// LOCK    | error seen, frozen until reset
module queue_calc_sequencer #(
    parameter int DATA_W      = 8,
    parameter int QUEUE_DEPTH = 5
) (
    input logic clk,
    input logic rst,
    queue_calc_sequencer_if.master bus
);
    localparam int DEPTH_W = $clog2(QUEUE_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    localparam logic [1:0] OP_PUSH    = 2'b00;
    localparam logic [1:0] OP_NOP     = 2'b01;
    localparam logic [1:0] OP_COMBINE = 2'b10;
    localparam logic [1:0] OP_POP     = 2'b11;

    localparam logic [1:0] E_OVERFLOW  = 2'b01;
    localparam logic [1:0] E_UNDERFLOW = 2'b10;
    localparam logic [1:0] E_FAULT     = 2'b11;

    logic [1:0]         state;
    logic [1:0]         issue_op;
    logic [2:0]         op_r;
    logic [DATA_W-1:0]  q_back_r;
    logic [DEPTH_W-1:0] depth;
    logic               after_issue;
    logic               res_valid_r;
    logic [DATA_W-1:0]  res_data_r;
    logic               err_r;
    logic [1:0]         err_code_r;

    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [2:0]         tok_code;
    logic               tok_ready;
    logic               fault;
    logic               accept;
    logic               op_legal;
    logic [DATA_W-1:0]  alu_result;

    assign a        = bus.q_top_conc[DATA_W-1:0];
    assign b        = bus.q_top_conc[2*DATA_W-1:DATA_W];
    assign tok_code = bus.tok_data[2:0];

    // Queue faults are ignored once locked and in the cycle after an issue,
    // where the queue flag may still reflect the op just applied.
    assign tok_ready = (state == S_IDLE) && !err_r;
    assign fault     = bus.q_is_err && !after_issue && !err_r;
    assign accept    = bus.tok_valid && tok_ready && !fault;

`ifdef QSEQ_DIV_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = (tok_code != 3'd6);
`endif

    // ALU on the two front entries, evaluated while in EXEC
    always_comb begin
        alu_result = '0;
        case (op_r)
            3'd0:    alu_result = a + b;
            3'd1:    alu_result = a - b;
            3'd2:    alu_result = a * b;
            3'd3:    alu_result = a & b;
            3'd4:    alu_result = a | b;
            3'd5:    alu_result = a ^ b;
`ifdef QSEQ_DIV_EN
            3'd6:    alu_result = (b == '0) ? '1 : a / b;
`endif
            default: alu_result = '0;
        endcase
    end

    // Sequencer FSM, depth mirror, result and error registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            issue_op    <= OP_NOP;
            op_r        <= '0;
            q_back_r    <= '0;
            depth       <= '0;
            after_issue <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            err_r       <= 1'b0;
            err_code_r  <= 2'b00;
        end else begin
            res_valid_r <= 1'b0;
            after_issue <= (state == S_ISSUE);
            if (fault) begin
                state      <= S_LOCK;
                err_r      <= 1'b1;
                err_code_r <= E_FAULT;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            if (!bus.tok_is_op) begin
                                if (depth == DEPTH_W'(QUEUE_DEPTH)) begin
                                    state      <= S_LOCK;
                                    err_r      <= 1'b1;
                                    err_code_r <= E_OVERFLOW;
                                end else begin
                                    q_back_r <= bus.tok_data;
                                    issue_op <= OP_PUSH;
                                    state    <= S_ISSUE;
                                end
                            end else if (!op_legal) begin
                                state      <= S_LOCK;
                                err_r      <= 1'b1;
                                err_code_r <= E_FAULT;
                            end else if (tok_code == 3'd7) begin
                                if (depth != DEPTH_W'(1)) begin
                                    state      <= S_LOCK;
                                    err_r      <= 1'b1;
                                    err_code_r <= E_UNDERFLOW;
                                end else begin
                                    issue_op    <= OP_POP;
                                    res_valid_r <= 1'b1;
                                    res_data_r  <= a;
                                    state       <= S_ISSUE;
                                end
                            end else if (depth < DEPTH_W'(2)) begin
                                state      <= S_LOCK;
                                err_r      <= 1'b1;
                                err_code_r <= E_UNDERFLOW;
                            end else begin
                                op_r  <= tok_code;
                                state <= S_EXEC;
                            end
                        end
                    end
                    S_EXEC: begin
                        q_back_r <= alu_result;
                        issue_op <= OP_COMBINE;
                        state    <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        state <= S_IDLE;
                        case (issue_op)
                            OP_PUSH:    depth <= depth + DEPTH_W'(1);
                            OP_COMBINE: depth <= depth - DEPTH_W'(1);
                            OP_POP:     depth <= '0;
                            default:    depth <= depth;
                        endcase
                    end
                    default: state <= S_LOCK;
                endcase
            end
        end
    end

    assign bus.tok_ready = tok_ready;
    assign bus.q_opcode  = (state == S_ISSUE) ? issue_op : OP_NOP;
    assign bus.q_back    = q_back_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.busy      = (state != S_IDLE);
    assign bus.err       = err_r;
    assign bus.err_code  = err_code_r;
endmodule

// File: tb/tb_queue_calc_sequencer.sv
// Directed bench for queue_calc_sequencer with a small behavioural operand queue.
// Build with QSEQ_DIV_EN defined to exercise the divide operator.
module tb_queue_calc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic q_err_inj = 1'b0;

    queue_calc_sequencer_if #(.DATA_W(8)) bus ();

    queue_calc_sequencer #(.DATA_W(8), .QUEUE_DEPTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural queue: entry 0 is the front (oldest)
    logic [7:0] mem [0:7];
    int         cnt = 0;
    logic [1:0] op_s = 2'b01;
    logic [7:0] back_s = 8'h00;

    // opcode log and result monitor, sampled on the falling edge
    logic [1:0] op_log   [0:255];
    logic [7:0] back_log [0:255];
    int         log_n = 0;
    int         res_seen = 0;
    logic [7:0] res_last = 8'h00;

    assign bus.q_top_conc = {(cnt >= 2) ? mem[1] : 8'hFF, (cnt >= 1) ? mem[0] : 8'hFF};
    assign bus.q_is_empty = (cnt == 0);
    assign bus.q_is_err   = q_err_inj;

    always @(negedge clk) begin
        op_s   <= bus.q_opcode;
        back_s <= bus.q_back;
        if (rst && bus.q_opcode != 2'b01 && log_n < 256) begin
            op_log[log_n]   <= bus.q_opcode;
            back_log[log_n] <= bus.q_back;
            log_n           <= log_n + 1;
        end
        if (rst && bus.res_valid) begin
            res_seen <= res_seen + 1;
            res_last <= bus.res_data;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            cnt <= 0;
        end else begin
            case (op_s)
                2'b00: if (cnt < 8) begin
                    mem[cnt] <= back_s;
                    cnt      <= cnt + 1;
                end
                2'b10: if (cnt >= 2) begin
                    for (int i = 0; i < 6; i++) mem[i] <= mem[i+2];
                    mem[cnt-2] <= back_s;
                    cnt        <= cnt - 1;
                end
                2'b11: if (cnt > 0) begin
                    for (int i = 0; i < 7; i++) mem[i] <= mem[i+1];
                    cnt <= cnt - 1;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int count_op(input int from, input logic [1:0] op);
        int n = 0;
        for (int i = from; i < log_n; i++) if (op_log[i] == op) n++;
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.tok_valid = 1'b0;
        q_err_inj = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // present one token, wait for its accept, then count falling edges until
    // tok_ready returns (or err rises); first_op is the opcode right after accept
    task automatic send_tok(input logic is_op, input logic [7:0] d,
                            output logic [1:0] first_op, output int lat);
        int n = 0;
        @(negedge clk);
        bus.tok_valid = 1'b1;
        bus.tok_is_op = is_op;
        bus.tok_data  = d;
        while (!bus.tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tok_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.tok_valid = 1'b0;
        bus.tok_data = 8'h00;
        lat = 0;
        first_op = 2'b01;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) first_op = bus.q_opcode;
        end while (!(bus.tok_ready || bus.err) && lat < 20);
        if (lat >= 20) check("ready_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tok_ready"}, bus.tok_ready, 1);
        check({tag, "_q_opcode"},  bus.q_opcode, 2'b01);
        check({tag, "_q_back"},    bus.q_back, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_data"},  bus.res_data, 0);
        check({tag, "_err"},       bus.err, 0);
        check({tag, "_err_code"},  bus.err_code, 0);
        check({tag, "_busy"},      bus.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fo;
        int lat;
        int mark;
        int rmark;

        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // 3 + 4, then result
        mark = log_n; rmark = res_seen;
        send_tok(0, 8'd3, fo, lat);
        check("push3_op", fo, 2'b00);
        check("push3_lat", lat, 2);
        send_tok(0, 8'd4, fo, lat);
        send_tok(1, 8'd0, fo, lat);
        check("add_exec_nop", fo, 2'b01);
        check("add_lat", lat, 3);
        send_tok(1, 8'd7, fo, lat);
        check("res_op", fo, 2'b11);
        check("res_lat", lat, 2);
        check("seq_len", log_n - mark, 4);
        check("seq0", {op_log[mark],   back_log[mark]},   {2'b00, 8'd3});
        check("seq1", {op_log[mark+1], back_log[mark+1]}, {2'b00, 8'd4});
        check("seq2", {op_log[mark+2], back_log[mark+2]}, {2'b10, 8'd7});
        check("seq3", op_log[mark+3], 2'b11);
        check("res_count", res_seen - rmark, 1);
        check("res_val", res_last, 8'd7);
        repeat (2) @(negedge clk);
        check("res_hold", bus.res_data, 8'd7);
        check("res_pulse_low", bus.res_valid, 0);
        check("q_empty_after_res", bus.q_is_empty, 1);

        // 5 - 7 wraps
        send_tok(0, 8'd5, fo, lat);
        send_tok(0, 8'd7, fo, lat);
        send_tok(1, 8'd1, fo, lat);
        check("sub_op", op_log[log_n-1], 2'b10);
        check("sub_back", back_log[log_n-1], 8'hFE);
        send_tok(1, 8'd7, fo, lat);
        check("sub_res", res_last, 8'hFE);

        // 20 * 13 truncated
        send_tok(0, 8'd20, fo, lat);
        send_tok(0, 8'd13, fo, lat);
        send_tok(1, 8'd2, fo, lat);
        check("mul_back", back_log[log_n-1], 8'h04);
        send_tok(1, 8'd7, fo, lat);
        check("mul_res", res_last, 8'h04);

        // overflow on the sixth push
        do_reset();
        mark = log_n;
        for (int i = 0; i < 5; i++) send_tok(0, 8'(10 + i), fo, lat);
        check("ovf_pushes", count_op(mark, 2'b00), 5);
        send_tok(0, 8'd99, fo, lat);
        check("ovf_no_push", count_op(mark, 2'b00), 5);
        check("ovf_err", bus.err, 1);
        check("ovf_code", bus.err_code, 2'b01);
        repeat (4) @(negedge clk);
        check("ovf_ready_low", bus.tok_ready, 0);
        check("ovf_opcode_nop", bus.q_opcode, 2'b01);

        // arith operator with a single entry
        do_reset();
        mark = log_n;
        send_tok(0, 8'd9, fo, lat);
        send_tok(1, 8'd3, fo, lat);
        check("und_code", bus.err_code, 2'b10);
        check("und_no_combine", count_op(mark, 2'b10), 0);

        // result with two entries
        do_reset();
        mark = log_n;
        send_tok(0, 8'd1, fo, lat);
        send_tok(0, 8'd2, fo, lat);
        send_tok(1, 8'd7, fo, lat);
        check("res_depth2_code", bus.err_code, 2'b10);
        check("res_depth2_no_pop", count_op(mark, 2'b11), 0);

        // queue fault beats a simultaneous token
        do_reset();
        mark = log_n;
        @(negedge clk);
        q_err_inj = 1'b1;
        bus.tok_valid = 1'b1;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = 8'd5;
        @(negedge clk);
        bus.tok_valid = 1'b0;
        q_err_inj = 1'b0;
        check("fault_err", bus.err, 1);
        check("fault_code", bus.err_code, 2'b11);
        check("fault_ready", bus.tok_ready, 0);
        repeat (3) @(negedge clk);
        check("fault_no_op", log_n - mark, 0);
        check("fault_q_empty", bus.q_is_empty, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("after_fault_reset");

        // divide operator
        do_reset();
        mark = log_n;
        send_tok(0, 8'd100, fo, lat);
        send_tok(0, 8'd7, fo, lat);
        send_tok(1, 8'd6, fo, lat);
`ifdef QSEQ_DIV_EN
        check("div_back", back_log[log_n-1], 8'd14);
        send_tok(1, 8'd7, fo, lat);
        check("div_res", res_last, 8'd14);
        send_tok(0, 8'd5, fo, lat);
        send_tok(0, 8'd0, fo, lat);
        send_tok(1, 8'd6, fo, lat);
        check("div0_back", back_log[log_n-1], 8'hFF);
        check("div0_no_err", bus.err, 0);
`else
        check("div_illegal_code", bus.err_code, 2'b11);
        check("div_no_combine", count_op(mark, 2'b10), 0);
`endif

        // reset during EXEC drops the combine
        do_reset();
        send_tok(0, 8'd1, fo, lat);
        send_tok(0, 8'd2, fo, lat);
        mark = log_n; rmark = res_seen;
        @(negedge clk);
        bus.tok_valid = 1'b1;
        bus.tok_is_op = 1'b1;
        bus.tok_data  = 8'd0;
        @(posedge clk);
        #1 bus.tok_valid = 1'b0;
        @(negedge clk);
        check("exec_busy", bus.busy, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("exec_rst_ready", bus.tok_ready, 1);
        check("exec_rst_q_empty", bus.q_is_empty, 1);
        send_tok(0, 8'd6, fo, lat);
        check("exec_rst_no_combine", count_op(mark, 2'b10), 0);
        check("exec_rst_push", {op_log[log_n-1], back_log[log_n-1]}, {2'b00, 8'd6});
        send_tok(1, 8'd7, fo, lat);
        check("exec_rst_res_ok", bus.err, 0);
        check("exec_rst_res", res_last, 8'd6);
        check("exec_rst_res_count", res_seen - rmark, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
